// File: rtl/serdes_tx.sv
// Byte-to-serial transmitter: FIFO-buffered words shifted out LSB first, zero-gap between words.
// Latency: bit 0 one cycle after acceptance into an idle block; ready drops only when the FIFO is full.
module serdes_tx #(
    parameter int   DATA_W     = 8,
    parameter int   FIFO_DEPTH = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ser_out,
    output logic                          frame_start,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] head;
    logic              empty;
    logic              full;
    logic              last_bit;
    logic              push;
    logic              pop;

    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign last_bit   = (bit_cnt == CW'(DATA_W - 1));

    // Ready depends on registered fullness only, so a same-edge pop never frees a slot early.
    assign tx_ready = rst_n && ena && !full;
    assign push     = tx_valid && tx_ready;
    assign pop      = ena && !empty && ((state == IDLE) || ((state == SHIFT) && last_bit));
    assign busy     = (state == SHIFT) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            ser_out     <= IDLE_LEVEL;
            frame_start <= 1'b0;
        end else if (ena) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                // Bit 0 goes straight to the output; the shifter keeps the remaining bits.
                rd_ptr      <= rd_ptr + 1'b1;
                shreg       <= head >> 1;
                ser_out     <= head[0];
                frame_start <= 1'b1;
                bit_cnt     <= '0;
                state       <= SHIFT;
            end else if ((state == SHIFT) && !last_bit) begin
                shreg       <= shreg >> 1;
                ser_out     <= shreg[0];
                frame_start <= 1'b0;
                bit_cnt     <= bit_cnt + 1'b1;
            end else begin
                state       <= IDLE;
                ser_out     <= IDLE_LEVEL;
                frame_start <= 1'b0;
                bit_cnt     <= '0;
            end
        end
    end

endmodule

// File: doc/serdes_tx.md
Name: serdes_tx

Overview:
Parallel-to-serial transmitter, the transmit-side counterpart of the team's deserializer (tt_um_serdes).
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte out LSB-first, one bit per clock, on a single serial line.
- Back-to-back bytes are sent with no gap, so a receiver counting 8-clock frames stays aligned.

Parameters:
DATA_W, 8, serial word width in bits.
FIFO_DEPTH, 2, input buffer entries; power of two, minimum 2.
IDLE_LEVEL, 0, ser_out level while no word is shifting.

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; 0 freezes all state
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial data, LSB first, registered
frame_start  output  1  high in the cycle ser_out carries bit 0 of a word
busy  output  1  shifter active or FIFO non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of buffered words, excluding the word in the shifter

Behaviour:
Reset (async assert, sync release):
- ser_out=IDLE_LEVEL, frame_start=0, busy=0, fifo_level=0, tx_ready=0 (it follows ena).
- FIFO pointers, shifter and bit_cnt are cleared.
- Reset mid-word aborts the word; buffered words are discarded.

Handshake:
- tx_ready = ena && (fifo_level < FIFO_DEPTH). Combinational from registered state only; no combinational path from tx_valid.
- A word is accepted at an edge where tx_valid && tx_ready; it is written to the FIFO tail.
- When full, tx_ready stays 0 even if the shifter pops at the same edge (no combinational pass-through). Ready rises the following cycle.

FSM, states IDLE and SHIFT:
- IDLE: ser_out=IDLE_LEVEL, frame_start=0. If ena and the FIFO is non-empty, pop the head into the shifter, drive bit 0 onto ser_out, set frame_start=1, bit_cnt=0, and go to SHIFT.
- SHIFT: each enabled edge, bit_cnt++ and ser_out = next bit. frame_start=0 for bits 1..DATA_W-1.
- At the edge leaving bit_cnt=DATA_W-1:
  - FIFO non-empty: pop the next word immediately; its bit 0 appears in the very next cycle with frame_start=1 (zero-gap); stay in SHIFT.
  - FIFO empty: go to IDLE; ser_out=IDLE_LEVEL.

Latency and counting:
- A word accepted at edge N into an idle block has bit 0 on ser_out after edge N+1, and bit k after edge N+1+k.
- A simultaneous push and pop on the same edge leaves fifo_level unchanged; the popped word is the older one.
- The FIFO pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.

ena=0:
- No state changes: shifter, bit_cnt, FIFO, ser_out and frame_start all hold.
- tx_ready=0.
- Resuming ena continues the word at the held bit with no bit lost or repeated.

busy = (state==SHIFT) || fifo_level!=0.

Test Plan:
- Reset with tx_valid=1 and tx_data=0xA5 -> tx_ready=0, ser_out=0, busy=0, fifo_level=0 during reset; no word accepted.
- Single word 0xA5 accepted at edge N -> ser_out = 1,0,1,0,0,1,0,1 over cycles N+1..N+8; frame_start only at N+1; IDLE at N+9.
- Four 0xFF words pushed back-to-back while tx_ready -> 32 consecutive 1 bits; frame_start at offsets 0,8,16,24; tx_ready drops while FIFO is full; no gap between words.
- Push 0x01 and 0x80 then hold tx_valid with 0x3C while full -> 0x3C accepted only after the first pop frees a slot; output order is 0x01, 0x80, 0x3C, LSB first.
- Drop ena for 5 cycles at bit 3 of 0xC3 -> ser_out holds bit 3 value (0); bits 4..7 resume unchanged; total frame spans 13 cycles.
- Assert rst_n=0 mid-word on bit 5 of 0x5A with one word buffered -> ser_out returns to IDLE_LEVEL immediately and fifo_level=0; after release there is no output until a new push.
